// File: rtl/ws281x_rx.sv
// WS281x NRZ stream receiver: decodes pulse widths into 24-bit pixels, buffers them
// in a small FIFO and exposes CFG/STATUS/DATA/PIXCNT over a single-cycle-ack register slave.
module ws281x_rx #(
  parameter int FIFO_DEPTH = 4,
  parameter int TH_W       = 8,
  parameter int RST_W      = 16
) (
  input  logic        mclk,
  input  logic        h_reset_n,
  input  logic        rxd,
  input  logic        reg_cs,
  input  logic        reg_wr,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  input  logic [3:0]  reg_be,
  output logic [31:0] reg_rdata,
  output logic        reg_ack,
  output logic        rx_intr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {S_DIS, S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t            state_q, state_d;
  logic              meta_q, meta_d, line_q, line_d, prev_q, prev_d;
  logic [31:0]       cfg_q, cfg_d, rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic [TH_W-1:0]   hcnt_q, hcnt_d;
  logic [RST_W-1:0]  lcnt_q, lcnt_d;
  logic [4:0]        bidx_q, bidx_d;
  logic [23:0]       shift_q, shift_d;
  logic [15:0]       pixcnt_q, pixcnt_d;
  logic              ovf_q, ovf_d, fd_q, fd_d, short_q, short_d, stuck_q, stuck_d;
  logic [23:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;

  logic enable, rise, fall, hcnt_sat, lo_sync, lo_done, bit_val;
  logic [TH_W-1:0]  th;
  logic [RST_W-1:0] rst_to;
  logic clr, frame_start, hcnt_start, hcnt_inc, lcnt_inc, bit_evt, stuck_evt, frame_end;
  logic acc, w1c, px_evt, do_pop, do_push, ovf_set;
  logic [23:0] px_dat;

  assign enable   = cfg_q[0];
  assign th       = cfg_q[8 +: TH_W];
  assign rst_to   = cfg_q[16 +: RST_W];
  assign rise     = line_q & ~prev_q;
  assign fall     = ~line_q & prev_q;
  assign hcnt_sat = (hcnt_q == '1);
  assign lo_sync  = (lcnt_q >= rst_to);
  assign lo_done  = (lcnt_q == rst_to);
  assign bit_val  = (hcnt_q > th);

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) state_q <= S_DIS;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_DIS;
    end else begin
      case (state_q)
        S_DIS:   state_d = S_SYNC;
        S_SYNC:  if (!line_q && lo_sync) state_d = S_IDLE;
        S_IDLE:  if (rise) state_d = S_HIGH;
        S_HIGH:  if (fall) state_d = S_LOW; else if (hcnt_sat) state_d = S_SYNC;
        S_LOW:   if (rise) state_d = S_HIGH; else if (lo_done) state_d = S_IDLE;
        default: state_d = S_DIS;
      endcase
    end
  end

  // hcnt starts at 1 on the rise cycle so it equals the high width when the fall is seen
  always_comb begin
    clr = 1'b0; frame_start = 1'b0; hcnt_start = 1'b0; hcnt_inc = 1'b0;
    lcnt_inc = 1'b0; bit_evt = 1'b0; stuck_evt = 1'b0; frame_end = 1'b0;
    if (!enable) begin
      clr = 1'b1;
    end else begin
      case (state_q)
        S_SYNC: lcnt_inc = !line_q && !lo_sync;
        S_IDLE: begin hcnt_start = rise; frame_start = rise; end
        S_HIGH: begin
          bit_evt   = fall;
          stuck_evt = !fall && hcnt_sat;
          hcnt_inc  = !fall && !hcnt_sat;
        end
        S_LOW: begin
          hcnt_start = rise;
          frame_end  = !rise && lo_done;
          lcnt_inc   = !rise && !lo_done;
        end
        default: clr = 1'b1;
      endcase
    end
  end

  assign acc     = reg_cs & ~ack_q;
  assign w1c     = acc & reg_wr & (reg_addr == 2'd1) & reg_be[0];
  assign px_evt  = bit_evt & (bidx_q == 5'd23);
  assign px_dat  = {shift_q[22:0], bit_val};
  assign do_pop  = acc & ~reg_wr & (reg_addr == 2'd2) & (cnt_q != '0);
  assign do_push = px_evt & ((cnt_q != LW'(FIFO_DEPTH)) | do_pop);
  assign ovf_set = px_evt & ~do_push;

  always_comb begin
    meta_d = rxd;
    line_d = meta_q;
    prev_d = line_q;
    hcnt_d = hcnt_start ? TH_W'(1) : (hcnt_inc ? hcnt_q + TH_W'(1) : '0);
    lcnt_d = lcnt_inc ? lcnt_q + RST_W'(1) : '0;

    bidx_d  = bidx_q;
    shift_d = shift_q;
    if (clr || frame_start || frame_end) begin
      bidx_d  = '0;
      shift_d = '0;
    end else if (bit_evt) begin
      bidx_d  = px_evt ? 5'd0 : bidx_q + 5'd1;
      shift_d = px_dat;
    end

    pixcnt_d = pixcnt_q;
    if (frame_start)                        pixcnt_d = '0;
    else if (px_evt && pixcnt_q != 16'hFFFF) pixcnt_d = pixcnt_q + 16'd1;

    // set events win over a same-cycle W1C
    ovf_d   = (ovf_q   & ~(w1c & reg_wdata[4])) | ovf_set;
    fd_d    = (fd_q    & ~(w1c & reg_wdata[5])) | frame_end;
    short_d = (short_q & ~(w1c & reg_wdata[6])) | (frame_end & (bidx_q != 5'd0));
    stuck_d = (stuck_q & ~(w1c & reg_wdata[7])) | stuck_evt;

    cfg_d = cfg_q;
    for (int i = 0; i < 4; i++)
      if (acc && reg_wr && reg_addr == 2'd0 && reg_be[i]) cfg_d[i*8 +: 8] = reg_wdata[i*8 +: 8];

    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + LW'(do_push) - LW'(do_pop);

    ack_d   = acc;
    rdata_d = '0;
    if (acc && !reg_wr) begin
      case (reg_addr)
        2'd0:    rdata_d = cfg_q;
        2'd1:    rdata_d = {24'h0, stuck_q, short_q, fd_q, ovf_q, 1'b0, 3'(cnt_q)};
        2'd2:    rdata_d = (cnt_q != '0) ? {8'h0, mem_q[rptr_q]} : '0;
        default: rdata_d = {16'h0, pixcnt_q};
      endcase
    end
  end

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      meta_q <= 1'b0; line_q <= 1'b0; prev_q <= 1'b0;
      cfg_q <= '0; rdata_q <= '0; ack_q <= 1'b0;
      hcnt_q <= '0; lcnt_q <= '0; bidx_q <= '0; shift_q <= '0; pixcnt_q <= '0;
      ovf_q <= 1'b0; fd_q <= 1'b0; short_q <= 1'b0; stuck_q <= 1'b0;
      wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
    end else begin
      meta_q <= meta_d; line_q <= line_d; prev_q <= prev_d;
      cfg_q <= cfg_d; rdata_q <= rdata_d; ack_q <= ack_d;
      hcnt_q <= hcnt_d; lcnt_q <= lcnt_d; bidx_q <= bidx_d; shift_q <= shift_d; pixcnt_q <= pixcnt_d;
      ovf_q <= ovf_d; fd_q <= fd_d; short_q <= short_d; stuck_q <= stuck_d;
      wptr_q <= wptr_d; rptr_q <= rptr_d; cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (do_push) mem_q[wptr_q] <= px_dat;
  end

  assign reg_ack   = ack_q;
  assign reg_rdata = rdata_q;
  assign rx_intr   = enable & ((cnt_q != '0) | fd_q | ovf_q);
endmodule

// File: tb/tb_ws281x_rx.sv
// Randomized scoreboard bench for ws281x_rx against a frame-level behavioural model.
module tb_ws281x_rx;
  localparam int DEPTH = 4;

  logic        mclk = 1'b0, h_reset_n = 1'b0, rxd = 1'b0;
  logic        reg_cs = 1'b0, reg_wr = 1'b0;
  logic [1:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [3:0]  reg_be = '0;
  logic [31:0] reg_rdata;
  logic        reg_ack, rx_intr;

  int total = 0, bad = 0;

  ws281x_rx #(.FIFO_DEPTH(DEPTH), .TH_W(8), .RST_W(16)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n), .rxd(rxd),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .rx_intr(rx_intr)
  );

  always #5 mclk = ~mclk;

  // scoreboard queues
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       nm_q[$];

  // behavioural model state
  logic [31:0] cfg_m = '0;
  int          th_m = 0, rto_m = 0;
  bit          en_m = 1'b0;
  logic [23:0] mfifo[$];
  bit          m_ovf = 0, m_fd = 0, m_short = 0, m_stuck = 0, m_inframe = 0;
  int          m_pixcnt = 0, m_bits = 0;
  logic [23:0] m_shift = '0;

  bit prev_ack = 1'b0;

  initial begin : monitor
    logic [31:0] e;
    bit c;
    string n;
    forever begin
      @(negedge mclk);
      if (prev_ack) begin
        total++;
        if (reg_ack !== 1'b0 || reg_rdata !== 32'h0) begin
          bad++;
          $display("FAIL ack_pulse: ack=%b rdata=%h, required ack=0 rdata=0", reg_ack, reg_rdata);
        end
      end
      if (reg_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: rdata=%h with no access pending", reg_rdata);
        end else begin
          e = exp_q.pop_front(); c = chk_q.pop_front(); n = nm_q.pop_front();
          if (c) begin
            total++;
            if (reg_rdata !== e) begin
              bad++;
              $display("FAIL %s: got %h expected %h", n, reg_rdata, e);
            end
          end
        end
      end
      prev_ack = (reg_ack === 1'b1);
    end
  end

  task automatic bus(input bit wr, input logic [1:0] a, input logic [31:0] wd, input logic [3:0] be);
    int n;
    @(posedge mclk); #1;
    reg_cs = 1'b1; reg_wr = wr; reg_addr = a; reg_wdata = wd; reg_be = be;
    n = 0;
    do begin @(negedge mclk); n++; end while (reg_ack !== 1'b1 && n < 20);
    if (reg_ack !== 1'b1) begin
      total++; bad++;
      $display("FAIL bus_timeout: ack=%b after %0d cycles, required 1", reg_ack, n);
    end
    reg_cs = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
    exp_q.push_back(e); chk_q.push_back(1'b1); nm_q.push_back(n);
    bus(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_q.push_back(32'h0); chk_q.push_back(1'b0); nm_q.push_back("write");
    bus(1'b1, a, d, be);
  endtask

  task automatic rd_status(input string n);
    rd(2'd1, {24'h0, m_stuck, m_short, m_fd, m_ovf, 1'b0, 3'(mfifo.size())}, n);
  endtask

  task automatic rd_data(input string n);
    logic [31:0] e;
    e = (mfifo.size() > 0) ? {8'h0, mfifo.pop_front()} : 32'h0;
    rd(2'd2, e, n);
  endtask

  task automatic rd_pixcnt(input string n);
    rd(2'd3, {16'h0, 16'(m_pixcnt)}, n);
  endtask

  task automatic w1c(input logic [7:0] v);
    wr(2'd1, {24'h0, v}, 4'h1);
    if (v[4]) m_ovf = 0;
    if (v[5]) m_fd = 0;
    if (v[6]) m_short = 0;
    if (v[7]) m_stuck = 0;
  endtask

  task automatic chk_intr(input string n);
    bit e;
    @(negedge mclk);
    e = en_m && (mfifo.size() != 0 || m_fd || m_ovf);
    total++;
    if (rx_intr !== e) begin
      bad++;
      $display("FAIL %s: rx_intr=%b expected %b", n, rx_intr, e);
    end
  endtask

  task automatic line(input bit v, input int n);
    @(posedge mclk); #1 rxd = v;
    repeat (n - 1) @(posedge mclk);
  endtask

  task automatic cfg_write(input bit en, input int th, input int rto);
    bit was_en;
    was_en = en_m;
    cfg_m = {16'(rto), 8'(th), 7'd0, en};
    wr(2'd0, cfg_m, 4'hF);
    th_m = th; rto_m = rto; en_m = en;
    if (!en) begin m_bits = 0; m_inframe = 0; m_shift = '0; end
    if (en && !was_en) line(1'b0, rto + 100);
  endtask

  // one bit: h high cycles then l low cycles; last=1 means the low time ends the frame
  task automatic tx_bit(input int h, input int l, input bit last);
    if (en_m && !m_inframe) begin m_inframe = 1; m_pixcnt = 0; m_bits = 0; end
    line(1'b1, h);
    line(1'b0, l);
    if (en_m) begin
      m_shift = {m_shift[22:0], (h > th_m)};
      m_bits++;
      if (m_bits == 24) begin
        if (mfifo.size() < DEPTH) mfifo.push_back(m_shift); else m_ovf = 1;
        if (m_pixcnt < 65535) m_pixcnt++;
        m_bits = 0;
      end
      if (last) begin
        m_fd = 1;
        if (m_bits != 0) m_short = 1;
        m_bits = 0; m_inframe = 0;
      end
    end
  endtask

  task automatic rand_bit(input bit v, input bit last);
    int h, l;
    if (v)              h = th_m + 2 + $urandom_range(0, 20);
    else if (th_m >= 3) h = $urandom_range(1, th_m - 2);
    else                h = 1;
    l = last ? rto_m + 60 : $urandom_range(8, 30);
    tx_bit(h, l, last);
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit last);
    for (int i = 23; i >= 0; i--) rand_bit(p[i], last && i == 0);
  endtask

  task automatic send_bits(input int n, input bit last);
    for (int i = 0; i < n; i++) rand_bit(1'($urandom_range(0, 1)), last && i == n - 1);
  endtask

  initial begin : stim
    logic [23:0] px;
    logic [23:0] fixed;
    int np, ex, th;

    h_reset_n = 1'b0;
    repeat (4) @(negedge mclk);
    total++;
    if (reg_ack !== 1'b0 || reg_rdata !== 32'h0 || rx_intr !== 1'b0) begin
      bad++;
      $display("FAIL in_reset: ack=%b rdata=%h intr=%b, required all 0", reg_ack, reg_rdata, rx_intr);
    end
    @(posedge mclk); #1 h_reset_n = 1'b1;

    rd(2'd0, 32'h0, "rst_cfg");
    rd(2'd1, 32'h0, "rst_status");
    rd(2'd2, 32'h0, "rst_data");
    rd(2'd3, 32'h0, "rst_pixcnt");
    chk_intr("rst_intr");

    // fixed-width decode of 0xA5C30F
    cfg_write(1'b1, 30, 500);
    chk_intr("idle_intr");
    fixed = 24'hA5C30F;
    for (int i = 23; i >= 0; i--)
      tx_bit(fixed[i] ? 40 : 20, (i == 0) ? 600 : (fixed[i] ? 25 : 45), i == 0);
    rd_status("dec_status");
    chk_intr("dec_intr");
    rd_data("dec_data");
    rd_pixcnt("dec_pixcnt");
    rd_status("dec_status_after_pop");
    w1c(8'h20);
    chk_intr("dec_intr_clear");

    // overflow: five pixels, no reads
    for (int k = 0; k < 5; k++) send_pixel(24'($urandom), k == 4);
    rd_status("ovf_status");
    chk_intr("ovf_intr");
    for (int k = 0; k < 4; k++) rd_data("ovf_data");
    rd_data("ovf_empty_data");
    w1c(8'h10);
    rd_status("ovf_cleared");
    w1c(8'h20);

    // short frame
    send_bits(10, 1'b1);
    rd_status("short_status");
    w1c(8'h60);

    // stuck high line from IDLE, then a normal frame
    m_pixcnt = 0;
    line(1'b1, 300);
    line(1'b0, rto_m + 100);
    m_stuck = 1; m_inframe = 0;
    rd_status("stuck_status");
    send_pixel(24'($urandom), 1'b1);
    rd_status("stuck_after_frame");
    rd_data("stuck_data");
    w1c(8'hF0);

    // disable mid-pixel, re-enable, full frame
    send_bits(12, 1'b0);
    cfg_write(1'b0, 30, 500);
    chk_intr("dis_intr");
    cfg_write(1'b1, 30, 500);
    send_pixel(24'($urandom), 1'b1);
    rd_status("reen_status");
    rd_data("reen_data");
    rd_data("reen_empty");
    rd_pixcnt("reen_pixcnt");
    w1c(8'hF0);

    // TH=0: every pulse decodes as 1
    cfg_write(1'b1, 0, 500);
    send_pixel(24'($urandom), 1'b1);
    rd_data("th0_data");
    w1c(8'hF0);

    // RST_TO=0: the first low cycle ends the frame
    cfg_write(1'b1, 30, 0);
    tx_bit(40, 60, 1'b1);
    rd_status("rto0_status");
    cfg_write(1'b1, 30, 500);
    w1c(8'hF0);

    // randomized frames
    for (int it = 0; it < 6; it++) begin
      th = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(10, 40);
      cfg_write(1'b1, th, 500);
      np = $urandom_range(1, 3);
      ex = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) begin
        px = 24'($urandom);
        send_pixel(px, ex == 0 && k == np - 1);
      end
      if (ex != 0) send_bits(ex, 1'b1);
      rd_status("rnd_status");
      rd_pixcnt("rnd_pixcnt");
      chk_intr("rnd_intr");
      for (int k = 0; k < np; k++) rd_data("rnd_data");
      w1c(8'hF0);
      chk_intr("rnd_intr_clear");
    end

    // reset in the middle of a frame
    send_pixel(24'($urandom), 1'b1);
    send_bits(5, 1'b0);
    @(posedge mclk); #1 h_reset_n = 1'b0;
    @(negedge mclk);
    total++;
    if (reg_ack !== 1'b0 || reg_rdata !== 32'h0 || rx_intr !== 1'b0) begin
      bad++;
      $display("FAIL midreset: ack=%b rdata=%h intr=%b, required all 0", reg_ack, reg_rdata, rx_intr);
    end
    repeat (3) @(posedge mclk);
    #1 h_reset_n = 1'b1;
    cfg_m = '0; en_m = 0; th_m = 0; rto_m = 0; mfifo.delete();
    m_ovf = 0; m_fd = 0; m_short = 0; m_stuck = 0; m_inframe = 0; m_pixcnt = 0; m_bits = 0;
    rd(2'd0, cfg_m, "midreset_cfg");
    rd_status("midreset_status");
    rd_data("midreset_data");
    rd_pixcnt("midreset_pixcnt");

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge mclk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d accesses never acknowledged, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ws281x_rx.md
# ws281x_rx

Single-channel WS281x serial-stream receiver with a register-bus slave. It decodes the one-wire NRZ pulse-width stream produced by a ws281x transmitter into 24-bit pixel words and buffers them in a 4-entry FIFO for software. It sits beside the ws281x driver in the peripheral wrapper, selected by its own block-select code. It is used for loopback self-test of the driver and for daisy-chain capture.

## Interface
Parameters:
- FIFO_DEPTH, 4: pixel FIFO entries. Must be a power of two.
- TH_W, 8: width of the bit-threshold field and the high-time counter.
- RST_W, 16: width of the reset-timeout field and the low-time counter.

Ports:
- mclk  in  1  system clock. It is the only clock.
- h_reset_n  in  1  asynchronous active-low reset.
- rxd  in  1  serial input, asynchronous to mclk.
- reg_cs  in  1  register chip select. It is held until reg_ack.
- reg_wr  in  1  1 = write, 0 = read.
- reg_addr  in  2  word address, taken from bus address bits [3:2].
- reg_wdata  in  32  write data.
- reg_be  in  4  byte enables for writes.
- reg_rdata  out  32  read data. It is valid while reg_ack is high.
- reg_ack  out  1  one-cycle access acknowledge.
- rx_intr  out  1  level interrupt.

## Operation
- rxd passes through a 2-flop synchronizer, then a previous-sample flop. The flop outputs give rise and fall detection.
- Registers, all byte-enabled:
  - 0x0 CFG, R/W, reset 0. Bit [0] is enable, bits [15:8] are TH, bits [31:16] are RST_TO.
  - 0x4 STATUS. Bits [2:0] are the FIFO level (RO). Bit [4] is OVF (W1C). Bit [5] is FRAME_DONE (W1C). Bit [6] is SHORT, meaning the frame ended with a partial pixel (W1C). Bit [7] is STUCK, meaning high time saturated (W1C).
  - 0x8 DATA, RO. Reads {8'h0, pixel[23:0]} from the FIFO head and pops it. A read while empty returns 0 and does not pop.
  - 0xC PIXCNT, RO. Bits [15:0] count pixels pushed since the last frame start, saturating at 0xFFFF.
- FSM states:
  - DIS: entered whenever enable=0. The counters, bit index and shift register are cleared. The FIFO and sticky bits are kept.
  - SYNC: the line must stay low for RST_TO cycles before moving to IDLE. A rise restarts the low count.
  - IDLE: on a rise, go to HIGH. This clears PIXCNT and the bit index.
  - HIGH: hcnt increments each cycle. On a fall, the decided bit is (hcnt > TH), it is shifted in MSB-first, and the FSM goes to LOW. If hcnt saturates at 2^TH_W-1, set STUCK and go to SYNC.
  - LOW: lcnt increments each cycle. On a rise, go to HIGH. When lcnt == RST_TO, the frame ends: set FRAME_DONE, set SHORT if the bit index is not 0, discard the partial bits, and go to IDLE.
- The 24th bit of a pixel pushes {shift[22:0], bit} to the FIFO and wraps the bit index to 0.
- A push while the FIFO is full drops the pixel and sets OVF, unless a DATA pop occurs in the same cycle. In that case both the pop and the push happen and OVF is not set.
- A W1C write and a same-cycle set event on the same bit: the set wins.
- rx_intr = enable & ((level != 0) | FRAME_DONE | OVF).
- RST_TO=0 or TH=0 is legal. With RST_TO=0 every low cycle ends the frame. With TH=0 every high pulse of at least 1 cycle decodes as 1.

## Timing
- Reset values: reg_ack=0, reg_rdata=0, rx_intr=0. The FSM is in DIS, the FIFO is empty, and all registers are 0.
- Register access:
  - reg_ack is registered: it rises the cycle after reg_cs is first sampled high and lasts one cycle.
  - Writes take effect at the ack edge. Pops happen at the ack edge.
  - reg_rdata is registered with reg_ack and is 0 when reg_ack is low.
- rxd to edge detect takes 3 mclk cycles.
- A bit decision happens on the cycle the fall is detected.
- A pushed pixel is visible in STATUS level and rx_intr one cycle after the push.
- A reset assertion mid-frame immediately clears all state. No partial pixel is retained.
- A DATA read in the same cycle as a push to an empty FIFO returns 0. The pushed pixel remains.

## Test plan
- Reset and idle:
  - Stimulus: apply reset, then read all four registers.
  - Required response: all read 0. rx_intr=0. reg_ack pulses exactly 1 cycle per access.
- Decode:
  - Stimulus: CFG = TH=30, RST_TO=500, en=1. Hold rxd low for 600 cycles. Send pixel 0xA5C30F, where a 0 bit is 20 high / 45 low cycles and a 1 bit is 40 high / 25 low cycles. Then hold low for 600 cycles.
  - Required response: STATUS=0x21. DATA=0x00A5C30F. PIXCNT=1. After the pop, level=0.
- Overflow:
  - Stimulus: send 5 pixels without reading.
  - Required response: level=4 and OVF=1. The DATA reads return pixels 1 to 4 in order. Write 0x10 to STATUS and OVF reads back 0.
- Short frame:
  - Stimulus: send 10 bits, then hold low for RST_TO cycles.
  - Required response: SHORT=1, FRAME_DONE=1, level=0.
- Stuck line:
  - Stimulus: hold rxd high for 300 cycles while in IDLE.
  - Required response: STUCK=1 and the FSM is in SYNC. The next valid frame after 500 low cycles decodes correctly.
- Disable mid-pixel:
  - Stimulus: clear en after 12 bits, then re-enable and send a full frame.
  - Required response: only the new pixel is in the FIFO.
